// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port.
// One transaction in flight; data has priority, bounded by a starvation counter for fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rsp,
  output logic [31:0] d_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | no transaction; grant one requester combinationally
  // ISSUE  | mem_req held with captured fields until mem_ready
  // WAIT   | read accepted; waiting for mem_rvalid

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        owner_data_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [3:0]  starve_q;
  logic        kill_q;
  logic        grant_f, grant_d;
  logic        fetch_live;

  always_comb begin
    state_d = state_q;
    grant_f = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // data wins unless fetch has waited STARVE_MAX data grants
        if (d_req && !(if_req && (starve_q == STARVE_LIM))) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_f = 1'b1;
        end
        if (grant_d || grant_f) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          state_d = we_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_gnt    = grant_f;
  assign d_gnt     = grant_d;
  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign fetch_live = grant_f || ((state_q != S_IDLE) && !owner_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else if (grant_d) begin
      owner_data_q <= 1'b1;
      we_q         <= d_we;
      addr_q       <= d_addr;
      wdata_q      <= d_wdata;
      be_q         <= d_be;
    end else if (grant_f) begin
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= if_addr;
      wdata_q      <= '0;
      be_q         <= 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (grant_f) begin
      starve_q <= '0;
    end else if (grant_d && if_req && (starve_q != STARVE_LIM)) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // a killed fetch still runs to completion on the memory side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else if (state_d == S_IDLE) begin
      kill_q <= 1'b0;
    end else if (fetch_live && if_kill) begin
      kill_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rsp     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rsp     <= 1'b0;
      if ((state_q == S_ISSUE) && mem_ready && we_q) begin
        d_rsp <= 1'b1;
      end
      if ((state_q == S_WAIT) && mem_rvalid) begin
        if (owner_data_q) begin
          d_rsp   <= 1'b1;
          d_rdata <= mem_rdata;
        end else if (!(kill_q || if_kill)) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch read, store with wait states,
// starvation ordering, kill, reset mid-transaction and back-to-back loads.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rsp;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rsp(d_rsp), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // inputs change at posedge+1, outputs are sampled at posedge+2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; if_kill = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    #2;
    vectors++;
    if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rsp, mem_we, mem_be} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b expected 0", {if_gnt, d_gnt, mem_req, if_rvalid, d_rsp, mem_we, mem_be});
    end
    vectors++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_read();
    tick();  // N
    if_req = 1; if_addr = 32'h100;
    #1;
    vectors++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      miscompares++; $display("FAIL fetch_gnt got %b expected 10", {if_gnt, d_gnt});
    end
    tick();  // N+1
    if_req = 0; mem_ready = 1;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
      miscompares++; $display("FAIL fetch_issue got %b %b %h %h %h", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();  // N+2
    mem_ready = 0;
    #1;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++; $display("FAIL fetch_wait_req got %b expected 0", mem_req);
    end
    tick();  // N+3
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if (if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL fetch_early_rvalid got %b expected 0", if_rvalid);
    end
    tick();  // N+4
    mem_rvalid = 0; mem_rdata = '0;
    #1;
    vectors++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL fetch_rsp got %b %h expected 1 deadbeef", if_rvalid, if_rdata);
    end
    tick();
    #1;
    vectors++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL fetch_hold got %b %h expected 0 deadbeef", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store();
    tick();  // N
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55; d_be = 4'h3;
    #1;
    vectors++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      miscompares++; $display("FAIL store_gnt got %b expected 01", {if_gnt, d_gnt});
    end
    for (int i = 0; i < 4; i++) begin  // N+1..N+4
      tick();
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
      if_req = 1;
      mem_ready = (i == 3);
      #1;
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, d_rsp} !==
          {1'b1, 1'b1, 32'h2000, 32'h55, 4'h3, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL store_issue cycle %0d got %b %b %h %h %h gnt %b rsp %b", i,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, d_rsp);
      end
    end
    tick();  // N+5
    if_req = 0; mem_ready = 0;
    #1;
    vectors++;
    if ({d_rsp, mem_req, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++; $display("FAIL store_rsp got %b %b %h expected 1 0 0", d_rsp, mem_req, d_rdata);
    end
    tick();
    #1;
    vectors++;
    if (d_rsp !== 1'b0) begin
      miscompares++; $display("FAIL store_rsp_pulse got %b expected 0", d_rsp);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_seq;
    int grants;
    exp_seq = 10'b1111011110;  // 1 = data grant, first grant in bit 9
    grants = 0;
    tick();
    if_req = 1; if_addr = 32'h500;
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h9; d_be = 4'hF;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE0000;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (if_gnt || d_gnt) begin
        vectors++;
        if ((d_gnt !== exp_seq[9 - grants]) || (if_gnt && d_gnt)) begin
          miscompares++;
          $display("FAIL starve_seq grant %0d got d=%b f=%b expected d=%b", grants, d_gnt, if_gnt, exp_seq[9 - grants]);
        end
        grants++;
      end
      if (grants == 10) break;
      tick();
    end
    vectors++;
    if (grants != 10) begin
      miscompares++; $display("FAIL starve_budget got %0d grants expected 10", grants);
    end
    tick();
    if_req = 0; d_req = 0; d_we = 0;
    tick(); tick(); tick();
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_kill();
    int fetch_pulses;
    fetch_pulses = 0;
    tick();  // N
    if_req = 1; if_addr = 32'h300;
    #1;
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++; $display("FAIL kill_gnt got %b expected 1", if_gnt);
    end
    tick();  // N+1
    if_req = 0; mem_ready = 1;
    #1; fetch_pulses += int'(if_rvalid);
    tick();  // N+2 in WAIT
    mem_ready = 0; if_kill = 1;
    #1; fetch_pulses += int'(if_rvalid);
    tick();  // N+3
    if_kill = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    #1; fetch_pulses += int'(if_rvalid);
    tick();  // N+4
    mem_rvalid = 0; mem_rdata = '0;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    #1; fetch_pulses += int'(if_rvalid);
    vectors++;
    if ({d_gnt, if_rdata} !== {1'b1, 32'hCAFE0000}) begin
      miscompares++; $display("FAIL kill_next_gnt got %b %h expected 1 cafe0000", d_gnt, if_rdata);
    end
    tick();
    d_req = 0; d_addr = '0; mem_ready = 1;
    #1; fetch_pulses += int'(if_rvalid);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5;
    #1; fetch_pulses += int'(if_rvalid);
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    #1; fetch_pulses += int'(if_rvalid);
    vectors++;
    if (fetch_pulses != 0) begin
      miscompares++; $display("FAIL kill_rvalid got %0d pulses expected 0", fetch_pulses);
    end
    vectors++;
    if ({d_rsp, d_rdata} !== {1'b1, 32'hA5A5}) begin
      miscompares++; $display("FAIL kill_load_rsp got %b %h expected 1 0000a5a5", d_rsp, d_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    tick();  // N
    d_req = 1; d_we = 0; d_addr = 32'h80;
    #1;
    vectors++;
    if (d_gnt !== 1'b1) begin
      miscompares++; $display("FAIL rstw_gnt got %b expected 1", d_gnt);
    end
    tick();  // N+1
    d_req = 0; d_addr = '0; mem_ready = 1;
    tick();  // N+2 in WAIT
    mem_ready = 0;
    #3;
    rst_n = 0;
    #1;
    vectors++;
    if ({mem_req, mem_addr, if_rdata, d_rdata, d_rsp, if_rvalid} !== 99'd0) begin
      miscompares++;
      $display("FAIL rstw_outputs got %b %h %h %h %b %b", mem_req, mem_addr, if_rdata, d_rdata, d_rsp, if_rvalid);
    end
    tick();  // N+3
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    vectors++;
    if ({d_rsp, if_rvalid} !== 2'b00) begin
      miscompares++; $display("FAIL rstw_stray_a got %b expected 00", {d_rsp, if_rvalid});
    end
    tick();  // N+4
    mem_rvalid = 0; mem_rdata = '0;
    d_req = 1; d_we = 0; d_addr = 32'h90;
    #1;
    vectors++;
    if ({d_rsp, if_rvalid, d_rdata, d_gnt} !== {2'b00, 32'h0, 1'b1}) begin
      miscompares++; $display("FAIL rstw_idle got rsp %b rv %b rd %h gnt %b", d_rsp, if_rvalid, d_rdata, d_gnt);
    end
    tick();  // N+5
    d_req = 0; d_addr = '0; mem_ready = 1;
    #1;
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h90}) begin
      miscompares++; $display("FAIL rstw_issue got %b %h expected 1 90", mem_req, mem_addr);
    end
    tick();  // N+6
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h11;
    tick();  // N+7
    mem_rvalid = 0; mem_rdata = '0;
    #1;
    vectors++;
    if ({d_rsp, d_rdata} !== {1'b1, 32'h11}) begin
      miscompares++; $display("FAIL rstw_load got %b %h expected 1 11", d_rsp, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int rsps;
    rsps = 0;
    tick();  // c0
    d_req = 1; d_we = 0; d_addr = 32'h10;
    #1; rsps += int'(d_rsp);
    vectors++;
    if (d_gnt !== 1'b1) begin
      miscompares++; $display("FAIL b2b_gnt0 got %b expected 1", d_gnt);
    end
    tick();  // c1
    d_addr = 32'h14; mem_ready = 1;
    #1; rsps += int'(d_rsp);
    vectors++;
    if ({d_gnt, mem_addr} !== {1'b0, 32'h10}) begin
      miscompares++; $display("FAIL b2b_issue0 got %b %h expected 0 10", d_gnt, mem_addr);
    end
    tick();  // c2
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1111;
    #1; rsps += int'(d_rsp);
    tick();  // c3
    mem_rvalid = 0; mem_rdata = '0;
    #1; rsps += int'(d_rsp);
    vectors++;
    if ({d_rsp, d_rdata, d_gnt} !== {1'b1, 32'h1111, 1'b1}) begin
      miscompares++; $display("FAIL b2b_rsp0 got %b %h gnt %b expected 1 1111 1", d_rsp, d_rdata, d_gnt);
    end
    tick();  // c4
    d_req = 0; d_addr = '0; mem_ready = 1;
    #1; rsps += int'(d_rsp);
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h14}) begin
      miscompares++; $display("FAIL b2b_issue1 got %b %h expected 1 14", mem_req, mem_addr);
    end
    tick();  // c5
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h2222;
    #1; rsps += int'(d_rsp);
    tick();  // c6
    mem_rvalid = 0; mem_rdata = '0;
    #1; rsps += int'(d_rsp);
    vectors++;
    if ({d_rsp, d_rdata} !== {1'b1, 32'h2222}) begin
      miscompares++; $display("FAIL b2b_rsp1 got %b %h expected 1 2222", d_rsp, d_rdata);
    end
    tick();  // c7
    #1; rsps += int'(d_rsp);
    tick();
    #1; rsps += int'(d_rsp);
    vectors++;
    if (rsps != 2) begin
      miscompares++; $display("FAIL b2b_count got %0d responses expected 2", rsps);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fetch_read();
    test_store();
    test_starvation();
    test_kill();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
